// File: rtl/pwm_multi.sv
// Multi-channel PWM with prescaler, shadowed period/mode/duty, edge or center counting.
// Optional per-channel output polarity when PWM_POLARITY_EN is defined.
module pwm_multi #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 4,
    parameter int PRESC_W  = 8,
    parameter int CH_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                en,
    input  logic [WIDTH-1:0]    period,
    input  logic [PRESC_W-1:0]  prescale,
    input  logic                center_mode,
    input  logic                wr_en,
    input  logic [CH_W-1:0]     wr_ch,
    input  logic [WIDTH-1:0]    wr_duty,
`ifdef PWM_POLARITY_EN
    input  logic [CHANNELS-1:0] pol,
`endif
    output logic [CHANNELS-1:0] sout,
    output logic                period_tick
);

    localparam logic [CH_W:0]  CH_LIMIT = (CH_W + 1)'(CHANNELS);
    localparam logic [WIDTH-1:0] ONE    = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [PRESC_W-1:0]  pcnt_q, pcnt_d;
    logic [WIDTH-1:0]    cnt_q, cnt_d;
    logic                down_q, down_d;
    logic [WIDTH-1:0]    act_period_q;
    logic                act_center_q;
    logic [WIDTH-1:0]    act_duty_q [CHANNELS];
    logic [WIDTH-1:0]    pend_q     [CHANNELS];
    logic [WIDTH-1:0]    pend_d     [CHANNELS];
    logic [CHANNELS-1:0] sout_q, sout_d;
    logic                period_tick_q;
    logic                tick_s, boundary_s, load_s, wr_valid_s;

    // Prescaler and main counter next-state; boundary is any tick whose next cnt is 0
    always_comb begin
        pcnt_d     = pcnt_q;
        cnt_d      = cnt_q;
        down_d     = down_q;
        boundary_s = 1'b0;
        tick_s     = (pcnt_q >= prescale);
        if (!en) begin
            pcnt_d = '0;
            cnt_d  = '0;
            down_d = 1'b0;
        end else if (tick_s) begin
            pcnt_d = '0;
            if (act_period_q == '0) begin
                boundary_s = 1'b1;
            end else if (!act_center_q) begin
                if (cnt_q == act_period_q) begin
                    boundary_s = 1'b1;
                end else begin
                    cnt_d = cnt_q + ONE;
                end
            end else if (!down_q) begin
                // With P=1 the peak is also the last state before wrapping to 0
                if (cnt_q == act_period_q) begin
                    if (act_period_q == ONE) begin
                        boundary_s = 1'b1;
                    end else begin
                        cnt_d  = cnt_q - ONE;
                        down_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + ONE;
                end
            end else begin
                if (cnt_q == ONE) begin
                    boundary_s = 1'b1;
                end else begin
                    cnt_d = cnt_q - ONE;
                end
            end
            if (boundary_s) begin
                cnt_d  = '0;
                down_d = 1'b0;
            end else begin
                down_d = down_d;
            end
        end else begin
            pcnt_d = pcnt_q + {{(PRESC_W-1){1'b0}}, 1'b1};
        end
    end

    // Pending duty update; out-of-range channels are dropped
    always_comb begin
        pend_d     = pend_q;
        wr_valid_s = wr_en && ({1'b0, wr_ch} < CH_LIMIT);
        if (wr_valid_s) begin
            pend_d[wr_ch] = wr_duty;
        end else begin
            pend_d = pend_q;
        end
        load_s = !en || boundary_s;
    end

    // Output compare against the current counter
    always_comb begin
        sout_d = '0;
        for (int i = 0; i < CHANNELS; i++) begin
`ifdef PWM_POLARITY_EN
            sout_d[i] = (en && (cnt_q < act_duty_q[i])) ^ pol[i];
`else
            sout_d[i] = en && (cnt_q < act_duty_q[i]);
`endif
        end
    end

    // State registers; active settings reload at boundaries and continuously while disabled
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pcnt_q        <= '0;
            cnt_q         <= '0;
            down_q        <= 1'b0;
            act_period_q  <= '0;
            act_center_q  <= 1'b0;
            sout_q        <= '0;
            period_tick_q <= 1'b0;
            for (int i = 0; i < CHANNELS; i++) begin
                act_duty_q[i] <= '0;
                pend_q[i]     <= '0;
            end
        end else begin
            pcnt_q        <= pcnt_d;
            cnt_q         <= cnt_d;
            down_q        <= down_d;
            sout_q        <= sout_d;
            period_tick_q <= en && boundary_s;
            pend_q        <= pend_d;
            if (load_s) begin
                act_period_q <= period;
                act_center_q <= center_mode;
                act_duty_q   <= pend_d;
            end
        end
    end

    assign sout        = sout_q;
    assign period_tick = period_tick_q;

endmodule
